voice_address_sequencer: RTL and testbench

//   Multi-voice successor to the single-note address incrementer. Generates one sample-ROM

---
 rtl/voice_address_sequencer.sv | 136 +++++++++++++
 tb/tb_voice_address_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_address_sequencer.sv
// voice_address_sequencer
//   Multi-voice sample-ROM address generator. Each voice owns a fixed-point
//   phase accumulator (ADDR_W integer bits, FRAC_W fraction bits). The
//   accumulator advances by that voice's pitch step on every audio tick. The
//   voice plays its sample once from start_addr to end_addr. A voice starts
//   on the rising edge of its key_on bit. It stops when the next phase would
//   pass end_addr or would wrap the accumulator.
//
//   Optional feature: define SAMPLE_LOOP_EN to add the loop_addr input. With
//   the feature on, a voice whose key is still held jumps back to loop_addr
//   at end-of-sample instead of finishing.
//
// Ports
//   Clk, Reset              clock; synchronous active-high reset
//   tick                    one-cycle audio-sample strobe
//   key_on[v]               per-voice gate level
//   start_addr/end_addr     per-voice sample bounds, end inclusive (flat, ADDR_W per voice)
//   step                    per-voice phase increment, Q(STEP_W-FRAC_W).FRAC_W
//   loop_addr               per-voice loop point (SAMPLE_LOOP_EN only)
//   addr_out                per-voice integer read address (registered)
//   active                  voice is playing
//   note_start / note_done  one-cycle pulses on (re)start / end-of-sample
module voice_address_sequencer #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 20,
    parameter int FRAC_W     = 8,
    parameter int STEP_W     = 12
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         tick,
    input  logic [NUM_VOICES-1:0]        key_on,
    input  logic [NUM_VOICES*ADDR_W-1:0] start_addr,
    input  logic [NUM_VOICES*ADDR_W-1:0] end_addr,
    input  logic [NUM_VOICES*STEP_W-1:0] step,
`ifdef SAMPLE_LOOP_EN
    input  logic [NUM_VOICES*ADDR_W-1:0] loop_addr,
`endif
    output logic [NUM_VOICES*ADDR_W-1:0] addr_out,
    output logic [NUM_VOICES-1:0]        active,
    output logic [NUM_VOICES-1:0]        note_start,
    output logic [NUM_VOICES-1:0]        note_done
);

    localparam int PH_W = ADDR_W + FRAC_W;

    typedef enum logic {IDLE, PLAY} state_t;

    // Key history is the only state shared at module level. Each bit still
    // belongs to exactly one voice.
    logic [NUM_VOICES-1:0] key_hist_q, key_hist_d;

    always_comb key_hist_d = key_on;

    always_ff @(posedge Clk) begin
        if (Reset) key_hist_q <= '0;
        else       key_hist_q <= key_hist_d;
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : gen_voice
        logic [ADDR_W-1:0] start_v, end_v;
        logic [STEP_W-1:0] step_v;
        logic [PH_W:0]     sum;      // one extra bit to catch accumulator wrap
        logic              trig, trig_ok, past_end, loop_ok;
        logic [PH_W-1:0]   loop_phase;

        state_t          state_q, state_d;
        logic [PH_W-1:0] phase_q, phase_d;
        logic            start_q, start_d;
        logic            done_q, done_d;

        assign start_v  = start_addr[v*ADDR_W +: ADDR_W];
        assign end_v    = end_addr[v*ADDR_W +: ADDR_W];
        assign step_v   = step[v*STEP_W +: STEP_W];
        assign trig     = key_on[v] & ~key_hist_q[v];
        assign trig_ok  = trig && (start_v <= end_v);
        assign sum      = {1'b0, phase_q} + {{(PH_W+1-STEP_W){1'b0}}, step_v};
        assign past_end = sum[PH_W] || (sum[PH_W-1:FRAC_W] > end_v);

`ifdef SAMPLE_LOOP_EN
        logic [ADDR_W-1:0] loop_v;
        assign loop_v     = loop_addr[v*ADDR_W +: ADDR_W];
        assign loop_ok    = key_on[v] && (start_v <= loop_v) && (loop_v <= end_v);
        assign loop_phase = {loop_v, {FRAC_W{1'b0}}};
`else
        assign loop_ok    = 1'b0;
        assign loop_phase = '0;
`endif

        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            start_d = 1'b0;
            done_d  = 1'b0;
            // A valid trigger overrides a tick in the same cycle. An invalid
            // trigger falls through, so the voice carries on as if no key edge
            // had occurred.
            if (trig_ok) begin
                state_d = PLAY;
                phase_d = {start_v, {FRAC_W{1'b0}}};
                start_d = 1'b1;
            end else if (state_q == PLAY && tick) begin
                if (!past_end) begin
                    phase_d = sum[PH_W-1:0];
                end else if (loop_ok) begin
                    phase_d = loop_phase;
                end else begin
                    // The phase is left alone here, so addr_out keeps the last
                    // in-range address after the note ends.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end

        always_ff @(posedge Clk) begin
            if (Reset) begin
                state_q <= IDLE;
                phase_q <= '0;
                start_q <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                start_q <= start_d;
                done_q  <= done_d;
            end
        end

        assign addr_out[v*ADDR_W +: ADDR_W] = phase_q[PH_W-1:FRAC_W];
        assign active[v]     = (state_q == PLAY);
        assign note_start[v] = start_q;
        assign note_done[v]  = done_q;
    end

endmodule

// File: tb/tb_voice_address_sequencer.sv
module tb_voice_address_sequencer;
    localparam int NV = 4;
    localparam int AW = 20;
    localparam int SW = 12;

    logic           Clk = 0;
    logic           Reset, tick;
    logic [NV-1:0]  key_on;
    logic [NV*AW-1:0] start_addr, end_addr;
    logic [NV*SW-1:0] step;
`ifdef SAMPLE_LOOP_EN
    logic [NV*AW-1:0] loop_addr;
`endif
    logic [NV*AW-1:0] addr_out;
    logic [NV-1:0]  active, note_start, note_done;

    int vectors = 0;
    int miscompares = 0;

    voice_address_sequencer dut (
        .Clk(Clk), .Reset(Reset), .tick(tick), .key_on(key_on),
        .start_addr(start_addr), .end_addr(end_addr), .step(step),
`ifdef SAMPLE_LOOP_EN
        .loop_addr(loop_addr),
`endif
        .addr_out(addr_out), .active(active),
        .note_start(note_start), .note_done(note_done)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: phase is a plain integer; addr is phase / 256.
    longint m_phase [NV];
    bit     m_play  [NV];
    bit     m_key   [NV];
    bit     m_start [NV];
    bit     m_done  [NV];

    function automatic longint fld(input logic [NV*AW-1:0] vec, input int v);
        logic [AW-1:0] f;
        f = vec[v*AW +: AW];
        return longint'(f);
    endfunction

    task automatic model_update();
        for (int v = 0; v < NV; v++) begin
            longint st, en, stp, nxt, lp;
            logic [SW-1:0] s;
            bit trig;
            st = fld(start_addr, v);
            en = fld(end_addr, v);
            s = step[v*SW +: SW];
            stp = longint'(s);
            lp = -1;
`ifdef SAMPLE_LOOP_EN
            lp = fld(loop_addr, v);
`endif
            if (Reset) begin
                m_phase[v] = 0; m_play[v] = 0; m_key[v] = 0;
                m_start[v] = 0; m_done[v] = 0;
            end else begin
                trig = key_on[v] && !m_key[v];
                m_key[v] = key_on[v];
                m_start[v] = 0;
                m_done[v] = 0;
                if (trig && st <= en) begin
                    m_phase[v] = st * 256;
                    m_play[v] = 1;
                    m_start[v] = 1;
                end else if (m_play[v] && tick) begin
                    nxt = m_phase[v] + stp;
                    if (nxt >= (64'd1 << 28) || (nxt / 256) > en) begin
                        if (key_on[v] && lp >= st && lp <= en) begin
                            m_phase[v] = lp * 256;
                        end else begin
                            m_play[v] = 0;
                            m_done[v] = 1;
                        end
                    end else begin
                        m_phase[v] = nxt;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [NV*AW-1:0] act, input logic [NV*AW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [NV*AW-1:0] ea;
        logic [NV-1:0] eact, es, ed;
        for (int v = 0; v < NV; v++) begin
            ea[v*AW +: AW] = AW'(m_phase[v] / 256);
            eact[v] = m_play[v];
            es[v] = m_start[v];
            ed[v] = m_done[v];
        end
        chk("addr_out", addr_out, ea);
        chk("active", {{(NV*AW-NV){1'b0}}, active}, {{(NV*AW-NV){1'b0}}, eact});
        chk("note_start", {{(NV*AW-NV){1'b0}}, note_start}, {{(NV*AW-NV){1'b0}}, es});
        chk("note_done", {{(NV*AW-NV){1'b0}}, note_done}, {{(NV*AW-NV){1'b0}}, ed});
    endtask

    // One clock: advance the model, take the edge, check 1 ns later.
    task automatic cyc();
        model_update();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic pin(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        chk(name, {{(NV*AW-AW){1'b0}}, act}, {{(NV*AW-AW){1'b0}}, exp});
    endtask

    task automatic set_voice(input int v, input logic [AW-1:0] st, input logic [AW-1:0] en, input logic [SW-1:0] sp);
        start_addr[v*AW +: AW] = st;
        end_addr[v*AW +: AW]   = en;
        step[v*SW +: SW]       = sp;
    endtask

    initial begin
        logic [AW-1:0] exp2 [4];
        Reset = 1; tick = 0; key_on = '0;
        start_addr = '0; end_addr = '0; step = '0;
`ifdef SAMPLE_LOOP_EN
        loop_addr = '0;
`endif
        @(negedge Clk);
        cyc(); cyc();
        pin("reset_addr", addr_out[19:0], 20'h0);
        pin("reset_active", {16'h0, active}, 20'h0);
        Reset = 0;

        // Directed 1: native pitch, one-shot to end
        set_voice(0, 20'h100, 20'h103, 12'h100);
        cyc();
        key_on[0] = 1; cyc();
        pin("t1_addr0", addr_out[19:0], 20'h100);
        pin("t1_start", {19'h0, note_start[0]}, 20'h1);
        pin("t1_active", {19'h0, active[0]}, 20'h1);
        cyc();
        pin("t1_start_pulse", {19'h0, note_start[0]}, 20'h0);
        tick = 1;
        cyc(); pin("t1_addr1", addr_out[19:0], 20'h101);
        cyc(); pin("t1_addr2", addr_out[19:0], 20'h102);
        cyc(); pin("t1_addr3", addr_out[19:0], 20'h103);
        cyc();
        pin("t1_done", {19'h0, note_done[0]}, 20'h1);
        pin("t1_inactive", {19'h0, active[0]}, 20'h0);
        pin("t1_hold", addr_out[19:0], 20'h103);
        tick = 0; cyc();

        // Directed 2: half pitch
        key_on[0] = 0; set_voice(0, 20'h10, 20'hFF, 12'h080); cyc();
        key_on[0] = 1; cyc();
        pin("t2_addr0", addr_out[19:0], 20'h10);
        exp2[0] = 20'h10; exp2[1] = 20'h11; exp2[2] = 20'h11; exp2[3] = 20'h12;
        for (int i = 0; i < 4; i++) begin
            tick = 1; cyc();
            pin("t2_half", addr_out[19:0], exp2[i]);
        end
        tick = 0;

        // Directed 3: invalid trigger, then trigger coincident with tick
        set_voice(1, 20'h200, 20'h1FF, 12'h100); cyc();
        key_on[1] = 1; cyc();
        pin("t3_nostart", {19'h0, note_start[1]}, 20'h0);
        pin("t3_noactive", {19'h0, active[1]}, 20'h0);
        key_on[1] = 0; set_voice(1, 20'h50, 20'h60, 12'h100); cyc();
        key_on[1] = 1; tick = 1; cyc();
        pin("t3_trig_tick", addr_out[39:20], 20'h50);
        tick = 0;

        // Directed 4: accumulator carry-out at top of memory, then retrigger
        set_voice(2, 20'hFFFFE, 20'hFFFFF, 12'h300); cyc();
        key_on[2] = 1; cyc();
        pin("t4_start", addr_out[59:40], 20'hFFFFE);
        tick = 1; cyc();
        pin("t4_done", {19'h0, note_done[2]}, 20'h1);
        pin("t4_hold", addr_out[59:40], 20'hFFFFE);
        tick = 0; key_on[2] = 0; set_voice(2, 20'h10, 20'h40, 12'h100); cyc();
        key_on[2] = 1; cyc();
        tick = 1; cyc(); cyc(); cyc();
        pin("t4_mid", addr_out[59:40], 20'h13);
        tick = 0; key_on[2] = 0; cyc();
        key_on[2] = 1; cyc();
        pin("t4_restart", addr_out[59:40], 20'h10);
        pin("t4_restart_nodone", {19'h0, note_done[2]}, 20'h0);

        // Directed 5: all voices at once, then reset mid-play
        key_on = '0;
        set_voice(0, 20'h1000, 20'h10FF, 12'h100);
        set_voice(1, 20'h2000, 20'h20FF, 12'h180);
        set_voice(2, 20'h3000, 20'h30FF, 12'h200);
        set_voice(3, 20'h4000, 20'h40FF, 12'h040);
        cyc();
        key_on = '1; cyc();
        tick = 1;
        for (int i = 0; i < 4; i++) cyc();
        pin("t5_v1", addr_out[39:20], 20'h2006);
        pin("t5_v3", addr_out[79:60], 20'h4001);
        Reset = 1; cyc();
        pin("t5_rst_addr", addr_out[79:60], 20'h0);
        pin("t5_rst_done", {16'h0, note_done}, 20'h0);
        Reset = 0; tick = 0; key_on = '0; cyc();

`ifdef SAMPLE_LOOP_EN
        // Directed 6: loop while held, finish after release
        set_voice(3, 20'h0, 20'h7, 12'h100);
        loop_addr[79:60] = 20'h4; cyc();
        key_on[3] = 1; cyc();
        tick = 1;
        for (int i = 0; i < 8; i++) cyc();
        pin("t6_looped", addr_out[79:60], 20'h4);
        pin("t6_nodone", {19'h0, note_done[3]}, 20'h0);
        key_on[3] = 0;
        cyc(); cyc(); cyc();
        pin("t6_end", addr_out[79:60], 20'h7);
        cyc();
        pin("t6_done", {19'h0, note_done[3]}, 20'h1);
        tick = 0; cyc();
`endif

        // Random phase
        for (int c = 0; c < 4000; c++) begin
            Reset = ($urandom_range(0, 599) == 0);
            tick = ($urandom_range(0, 2) == 0);
            for (int v = 0; v < NV; v++) begin
                if ($urandom_range(0, 19) == 0) begin
                    logic [AW-1:0] st, en;
                    if ($urandom_range(0, 5) == 0) st = 20'hFFFC0 + AW'($urandom_range(0, 'h3F));
                    else st = AW'($urandom_range(0, 'h40));
                    if ($urandom_range(0, 9) == 0) en = st - 20'h1;
                    else en = st + AW'($urandom_range(0, 'h20));
                    set_voice(v, st, en, SW'($urandom_range(0, 'h300)));
`ifdef SAMPLE_LOOP_EN
                    loop_addr[v*AW +: AW] = st + AW'($urandom_range(0, 'h24));
`endif
                end
                if ($urandom_range(0, 11) == 0) key_on[v] = ~key_on[v];
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
